// File: rtl/score_display_driver.sv
// score_display_driver
//   Converts a binary score to four BCD digits with an iterative double-dabble
//   FSM, or substitutes a fixed message, and time-multiplexes the four digit
//   codes onto the shared cathode-decoder input while scanning the anodes.
//
// Ports
//   i_Clk          system clock, rising edge
//   i_Rst_n        asynchronous active-low reset
//   i_Score        14-bit binary score (saturates to 9999)
//   i_Score_Valid  one-cycle strobe, samples i_Score
//   i_Mode         0 score, 1 "LOSE", 2 "----", 3 blank
//   o_Digit        8-bit digit code for the current scan position
//   o_Anode        active-low anode enables, bit 0 = units digit
//   o_Busy         BCD conversion in progress
module score_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [13:0] i_Score,
  input  logic        i_Score_Valid,
  input  logic [1:0]  i_Mode,
  output logic [7:0]  o_Digit,
  output logic [3:0]  o_Anode,
  output logic        o_Busy
);

  localparam logic [19:0] DIV_LAST  = 20'(REFRESH_DIV - 1);
  localparam logic [13:0] SCORE_MAX = 14'd9999;
  localparam logic [3:0]  LAST_ITER = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  state_t state, state_nxt;

  logic [13:0]      bin_sr;
  logic [15:0]      bcd;
  logic [15:0]      bcd_adj;
  logic [3:0]       iter;
  logic             pend_vld;
  logic [13:0]      pend_val;
  logic [3:0][3:0]  disp;
  logic [13:0]      score_sat;
  logic             load_new;
  logic [13:0]      load_val;

  logic [19:0]      div_cnt;
  logic [1:0]       scan_idx;
  logic [1:0]       scan_nxt;
  logic [3:0]       lz;
  logic [3:0]       anode_nxt;
  logic [7:0]       code_nxt;

  assign score_sat = (i_Score > SCORE_MAX) ? SCORE_MAX : i_Score;

  // A capture happens from IDLE on a strobe, or straight out of COMMIT when a
  // strobe arrives on that edge or one is pending; the live strobe is newest.
  always_comb begin
    load_new = 1'b0;
    load_val = score_sat;
    if (state == ST_IDLE && i_Score_Valid) begin
      load_new = 1'b1;
    end else if (state == ST_COMMIT && (i_Score_Valid || pend_vld)) begin
      load_new = 1'b1;
      load_val = i_Score_Valid ? score_sat : pend_val;
    end
  end

  // ---------------- conversion FSM ----------------
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (i_Score_Valid) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (iter == LAST_ITER) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = load_new ? ST_SHIFT : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_Busy = (state != ST_IDLE);
  end

  // ---------------- double-dabble datapath ----------------
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bin_sr <= '0;
      bcd    <= '0;
      iter   <= '0;
    end else if (load_new) begin
      bin_sr <= load_val;
      bcd    <= '0;
      iter   <= '0;
    end else if (state == ST_SHIFT) begin
      bcd    <= {bcd_adj[14:0], bin_sr[13]};
      bin_sr <= {bin_sr[12:0], 1'b0};
      iter   <= iter + 4'd1;
    end
  end

  // One-deep pending slot: newest strobe during a conversion wins. It is always
  // emptied in COMMIT, either by the capture it triggers or superseded by a
  // strobe arriving on that same edge.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      pend_vld <= 1'b0;
      pend_val <= '0;
    end else if (state == ST_COMMIT) begin
      pend_vld <= 1'b0;
    end else if (state == ST_SHIFT && i_Score_Valid) begin
      pend_vld <= 1'b1;
      pend_val <= score_sat;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)                disp <= '0;
    else if (state == ST_COMMIT) disp <= bcd;
  end

  // ---------------- scan ----------------
  assign scan_nxt  = scan_idx + 2'd1;
  assign anode_nxt = ~(4'b0001 << scan_nxt);

  // Leading-zero flags: a digit blanks while it and all higher digits are 0.
  always_comb begin
    lz    = '0;
    lz[3] = (disp[3] == 4'd0);
    lz[2] = lz[3] && (disp[2] == 4'd0);
    lz[1] = lz[2] && (disp[1] == 4'd0);
  end

  always_comb begin
    code_nxt = 8'hFF;
    unique case (i_Mode)
      2'd0: code_nxt = lz[scan_nxt] ? 8'hFF : {4'h0, disp[scan_nxt]};
      2'd1: begin
        unique case (scan_nxt)
          2'd0: code_nxt = 8'h0E;
          2'd1: code_nxt = 8'h0A;
          2'd2: code_nxt = 8'h00;
          2'd3: code_nxt = 8'h11;
          default: code_nxt = 8'hFF;
        endcase
      end
      2'd2: code_nxt = 8'hFE;
      2'd3: code_nxt = 8'hFF;
      default: code_nxt = 8'hFF;
    endcase
  end

  // Anode and digit code load on the same edge so a lit anode never shows a
  // code belonging to a different position.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      div_cnt  <= '0;
      scan_idx <= '0;
      o_Anode  <= 4'b1110;
      o_Digit  <= 8'h00;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      scan_idx <= scan_nxt;
      o_Anode  <= anode_nxt;
      o_Digit  <= code_nxt;
    end else begin
      div_cnt  <= div_cnt + 20'd1;
    end
  end

endmodule

// File: tb/tb_score_display_driver.sv
// Testbench for score_display_driver: each task drives one scenario and checks
// it inline against a decimal-arithmetic model of what the display must show.
module tb_score_display_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] score;
  logic        valid;
  logic [1:0]  mode;
  logic [7:0]  digit;
  logic [3:0]  anode;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_display_driver #(.REFRESH_DIV(DIV)) dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_Score       (score),
    .i_Score_Valid (valid),
    .i_Mode        (mode),
    .o_Digit       (digit),
    .o_Anode       (anode),
    .o_Busy        (busy)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: code shown at position idx for a displayed value v in a given mode.
  function automatic logic [7:0] exp_code(int v, int m, int idx);
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    case (m)
      1: begin
        case (idx)
          0: return 8'h0E;
          1: return 8'h0A;
          2: return 8'h00;
          default: return 8'h11;
        endcase
      end
      2: return 8'hFE;
      3: return 8'hFF;
      default: begin
        if (idx > 0 && v < p) return 8'hFF;
        return 8'((v / p) % 10);
      end
    endcase
  endfunction

  function automatic int sat(int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int anode_idx(logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Let pending scan steps settle, then record one full scan period. bad counts
  // malformed anodes, inconsistent codes at a position and unseen positions.
  task automatic capture_scan(output logic [3:0][7:0] obs, output int bad);
    logic [3:0] seen;
    int p;
    bad  = 0;
    seen = '0;
    obs  = '0;
    repeat (4*DIV + 2) @(negedge clk);
    for (int c = 0; c < 4*DIV; c++) begin
      @(negedge clk);
      p = anode_idx(anode);
      if (p < 0) begin
        bad++;
      end else begin
        if (seen[p] && obs[p] !== digit) bad++;
        obs[p]  = digit;
        seen[p] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) if (!seen[i]) bad++;
  endtask

  task automatic strobe_and_wait(input int v, output int timed_out);
    score = 14'(v);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    timed_out = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] ea;
    int idx;
    rst_n = 1'b0;
    valid = 1'b0;
    score = '0;
    mode  = 2'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (anode !== 4'b1110) begin n_fail++; $display("FAIL reset_anode: got %b want 1110", anode); end
    n_checks++;
    if (digit !== 8'h00) begin n_fail++; $display("FAIL reset_digit: got %h want 00", digit); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      idx = (j / 4) % 4;
      ea  = ~(4'b0001 << idx);
      n_checks++;
      if (anode !== ea) begin
        n_fail++; $display("FAIL scan_anode cyc %0d: got %b want %b", j, anode, ea);
      end
      n_checks++;
      if (digit !== exp_code(0, 0, idx)) begin
        n_fail++; $display("FAIL scan_digit cyc %0d: got %h want %h", j, digit, exp_code(0, 0, idx));
      end
    end
  endtask

  task automatic test_score_1234();
    int busy_cnt, first_low, stale, p, bad;
    logic [3:0][7:0] obs;
    busy_cnt = 0; first_low = 0; stale = 0;
    score = 14'd1234;
    valid = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      valid = 1'b0;
      if (busy) begin
        busy_cnt++;
        p = anode_idx(anode);
        if (p < 0 || digit !== exp_code(0, 0, p)) stale++;
      end else if (first_low == 0) begin
        first_low = n;
      end
    end
    n_checks++;
    if (busy_cnt !== 15) begin n_fail++; $display("FAIL busy_len_1234: got %0d want 15", busy_cnt); end
    n_checks++;
    if (first_low !== 16) begin n_fail++; $display("FAIL busy_fall_1234: got cycle %0d want 16", first_low); end
    n_checks++;
    if (stale !== 0) begin n_fail++; $display("FAIL midconv_display: got %0d changed samples want 0", stale); end
    capture_scan(obs, bad);
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL scan_shape_1234: got %0d anomalies want 0", bad); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs[i] !== exp_code(1234, 0, i)) begin
        n_fail++; $display("FAIL digit_1234[%0d]: got %h want %h", i, obs[i], exp_code(1234, 0, i));
      end
    end
  endtask

  task automatic test_values();
    int vals[3] = '{7, 1005, 12000};
    int to, bad;
    logic [3:0][7:0] obs;
    foreach (vals[k]) begin
      strobe_and_wait(vals[k], to);
      n_checks++;
      if (to !== 0) begin n_fail++; $display("FAIL busy_timeout val %0d: got timeout want idle", vals[k]); end
      capture_scan(obs, bad);
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL scan_shape val %0d: got %0d want 0", vals[k], bad); end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs[i] !== exp_code(sat(vals[k]), 0, i)) begin
          n_fail++;
          $display("FAIL digit val %0d [%0d]: got %h want %h", vals[k], i, obs[i], exp_code(sat(vals[k]), 0, i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt, first_low, gap, wrong42, p, bad;
    logic [3:0][7:0] obs;
    busy_cnt = 0; first_low = 0; gap = 0; wrong42 = 0;
    score = 14'd42;
    valid = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      valid = 1'b0;
      if (n == 5) begin score = 14'd99;  valid = 1'b1; end
      if (n == 9) begin score = 14'd300; valid = 1'b1; end
      if (busy) begin
        busy_cnt++;
        if (first_low != 0) gap++;
      end else if (first_low == 0) begin
        first_low = n;
      end
      if (n >= 21 && n <= 30) begin
        p = anode_idx(anode);
        if (p < 0 || digit !== exp_code(42, 0, p)) wrong42++;
      end
    end
    n_checks++;
    if (busy_cnt !== 30) begin n_fail++; $display("FAIL b2b_busy_len: got %0d want 30", busy_cnt); end
    n_checks++;
    if (first_low !== 31 || gap !== 0) begin
      n_fail++; $display("FAIL b2b_busy_cont: got fall %0d gaps %0d want fall 31 gaps 0", first_low, gap);
    end
    n_checks++;
    if (wrong42 !== 0) begin n_fail++; $display("FAIL b2b_first_commit: got %0d non-42 samples want 0", wrong42); end
    capture_scan(obs, bad);
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL b2b_scan_shape: got %0d want 0", bad); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs[i] !== exp_code(300, 0, i)) begin
        n_fail++; $display("FAIL b2b_digit[%0d]: got %h want %h", i, obs[i], exp_code(300, 0, i));
      end
    end
  endtask

  task automatic test_modes();
    int bad;
    logic [3:0][7:0] obs;
    for (int m = 1; m <= 3; m++) begin
      mode = 2'(m);
      capture_scan(obs, bad);
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL mode%0d_scan: got %0d anomalies want 0", m, bad); end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs[i] !== exp_code(300, m, i)) begin
          n_fail++; $display("FAIL mode%0d_digit[%0d]: got %h want %h", m, i, obs[i], exp_code(300, m, i));
        end
      end
    end
    mode = 2'd0;
  endtask

  task automatic test_random();
    int v, m, to, bad;
    logic [3:0][7:0] obs;
    for (int t = 0; t < 10; t++) begin
      v = int'($urandom_range(0, 16383));
      m = int'($urandom_range(0, 3));
      mode = 2'(m);
      strobe_and_wait(v, to);
      n_checks++;
      if (to !== 0) begin n_fail++; $display("FAIL rand_timeout v %0d: got timeout want idle", v); end
      capture_scan(obs, bad);
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL rand_scan v %0d m %0d: got %0d want 0", v, m, bad); end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs[i] !== exp_code(sat(v), m, i)) begin
          n_fail++;
          $display("FAIL rand_digit v %0d m %0d [%0d]: got %h want %h", v, m, i, obs[i], exp_code(sat(v), m, i));
        end
      end
    end
    mode = 2'd0;
  endtask

  task automatic test_reset_mid();
    int to, busy_seen, bad;
    logic [3:0][7:0] obs;
    mode = 2'd0;
    strobe_and_wait(9999, to);
    n_checks++;
    if (to !== 0) begin n_fail++; $display("FAIL rmid_setup: got timeout want idle"); end
    score = 14'd5555;
    valid = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      valid = 1'b0;
      if (n == 3) begin score = 14'd77; valid = 1'b1; end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (anode !== 4'b1110) begin n_fail++; $display("FAIL rmid_anode: got %b want 1110", anode); end
    n_checks++;
    if (digit !== 8'h00) begin n_fail++; $display("FAIL rmid_digit: got %h want 00", digit); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    n_checks++;
    if (busy_seen !== 0) begin n_fail++; $display("FAIL rmid_pending_cleared: got %0d busy cycles want 0", busy_seen); end
    capture_scan(obs, bad);
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL rmid_scan: got %0d want 0", bad); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs[i] !== exp_code(0, 0, i)) begin
        n_fail++; $display("FAIL rmid_digit[%0d]: got %h want %h", i, obs[i], exp_code(0, 0, i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_score_1234();
    test_values();
    test_back_to_back();
    test_modes();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_display_driver.md
# score_display_driver

Producer side of the 8-bit digit-code interface consumed by the seven-segment cathode decoder. Converts a binary snake score to four BCD digits with an iterative double-dabble FSM, or substitutes a fixed message, then time-multiplexes the four digit codes onto the shared decoder input while driving the active-low anodes. It sits between the game logic (score and game state) and the decoder and anode pins on the board.

## Interface
- REFRESH_DIV, 100000: clock cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range 2 to 2^20-1.
- i_Clk  input  1  system clock, rising edge.
- i_Rst_n  input  1  reset, asynchronous and active-low.
- i_Score  input  14  binary score; values above 9999 saturate to 9999.
- i_Score_Valid  input  1  one-cycle strobe; sample i_Score.
- i_Mode  input  2  display source: 0 score, 1 "LOSE", 2 "----", 3 blank. Level input, resampled every scan step.
- o_Digit  output  8  digit code to the cathode decoder.
- o_Anode  output  4  active-low anode enables; bit 0 is the rightmost (units) digit.
- o_Busy  output  1  BCD conversion in progress.

## Operation
- Digit codes: 0x00-0x09 numerals, 0x0A S, 0x0B R, 0x0C C, 0x0E E, 0x11 L, 0xFE minus, 0xFF blank. No other code is ever driven.
- Conversion FSM states:
  - IDLE: a strobe latches min(i_Score, 9999) into the 14-bit shift register, clears the 16-bit BCD register, and moves to SHIFT.
  - SHIFT: 14 iterations, one per clock. Each iteration first adds 3 to every BCD nibble that is ≥5, then shifts {BCD, bin} left by 1.
  - COMMIT: copies the BCD into the display registers D3..D0, then moves to IDLE.
- A strobe in SHIFT or COMMIT is not dropped. It is held in a one-deep pending register; a later strobe overwrites it, so the newest value wins. When COMMIT completes with a value pending, the FSM goes directly to a new capture (IDLE is skipped for that cycle).
- Leading-zero blanking in mode 0: D3, D2 and D1 show 0xFF while they and every more-significant digit are 0. D0 always shows its numeral.
- Mode 1 patterns, written D3..D0: L,0,S,E, i.e. 0x11,0x00,0x0A,0x0E. Mode 2: 0xFE on all digits. Mode 3: 0xFF on all digits. The anodes keep scanning in every mode.
- Scan: a 20-bit divider counts 0..REFRESH_DIV-1. At terminal count the scan index advances 0→1→2→3→0.
- o_Anode has exactly one bit low, at the scan index. o_Digit is the code for that index.

## Timing
- Reset values: state IDLE, display registers 0, pending register empty, divider 0, scan index 0.
- Outputs in reset: o_Anode = 4'b1110, o_Digit = 0x00, o_Busy = 0. Reset display reads "   0".
- o_Anode and o_Digit are both registered and update on the same edge, so no anode is ever enabled with a stale code.
- Latency: a strobe sampled at edge k gives capture at k and o_Busy=1 from after k. Shift iterations run on edges k+1..k+14. Commit is at k+15, and o_Busy falls after k+15 unless a value is pending.
- The new value appears on o_Digit at the first scan step after k+15. Displayed digits never change in the middle of a conversion.
- Each anode dwells exactly REFRESH_DIV cycles, and the full scan period is 4×REFRESH_DIV. Scan timing is independent of the conversion FSM and of i_Mode.
- An i_Mode change takes effect on the next scan-step edge.
- Reset asserted mid-conversion aborts it, clears any pending value, and forces the reset values asynchronously. The first capture after release needs a fresh strobe.

## Test plan
- Reset, REFRESH_DIV=4 -> o_Anode cycles 1110,1101,1011,0111 with 4 cycles each. o_Digit = 0x00, 0xFF, 0xFF, 0xFF.
- Strobe i_Score=1234 in mode 0 -> o_Busy high for exactly 15 cycles. The scan then shows D0..D3 = 0x04, 0x03, 0x02, 0x01.
- Strobe 7 -> D0..D3 = 0x07, 0xFF, 0xFF, 0xFF. Strobe 1005 -> 0x05, 0x00, 0x00, 0x01. Strobe 12000 -> 0x09 on all digits.
- Strobe 42, then 99 at capture+5, then 300 at capture+9 -> 42 commits first. A second conversion of 300 follows immediately, with o_Busy continuous for 30 cycles; 99 is never displayed.
- Mode 1 -> D0..D3 = 0x0E, 0x0A, 0x00, 0x11. Mode 2 -> all 0xFE. Mode 3 -> all 0xFF, with the anodes still scanning.
- Assert i_Rst_n low at shift iteration 7 of score 5555 -> outputs return to the reset values asynchronously. After release the display reads "   0" until a new strobe arrives.
